// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port unified memory (optional watchdog: ARB_TIMEOUT_EN)
module mem_port_arbiter #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_IReqF,
   input  logic [ADDRESS_WIDTH-1:0] i_IAddrF,
   output logic [DATA_WIDTH-1:0]    o_InstrF,
   input  logic                     i_DReqM,
   input  logic                     i_DWeM,
   input  logic [ADDRESS_WIDTH-1:0] i_DAddrM,
   input  logic [DATA_WIDTH-1:0]    i_DWdataM,
   output logic [DATA_WIDTH-1:0]    o_ReadDataM,
   input  logic                     i_StallExtF,
   output logic                     o_MemStall,
   output logic                     o_MemReq,
   output logic                     o_MemWe,
   output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
   output logic [DATA_WIDTH-1:0]    o_MemWdata,
   input  logic [DATA_WIDTH-1:0]    i_MemRdata,
   input  logic                     i_MemReady,
   output logic                     o_Timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_BUSY = 2'd1,
      I_BUSY = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_idone;
   logic                  r_ddone;
   logic [DATA_WIDTH-1:0] r_ibuf;
   logic [DATA_WIDTH-1:0] r_dbuf;

   logic w_dpend;
   logic w_ipend;
   logic w_dnow;
   logic w_inow;
   logic w_stall;
   logic w_dclr;
   logic w_iclr;

   // A requester is pending while it asks and its result is not yet buffered.
   assign w_dpend = i_DReqM & ~r_ddone;
   assign w_ipend = i_IReqF & ~r_idone;
   assign w_dnow  = (r_state == D_BUSY) & i_MemReady;
   assign w_inow  = (r_state == I_BUSY) & i_MemReady;

   // A completion arriving this cycle releases its requester without waiting for the buffer.
   assign w_stall = (i_IReqF & ~r_idone & ~w_inow) | (i_DReqM & ~r_ddone & ~w_dnow);

   // Pipeline advance consumes buffered results; fetch also waits for the hazard unit.
   assign w_dclr = ~w_stall;
   assign w_iclr = ~w_stall & ~i_StallExtF;

   assign o_MemStall  = w_stall;
   assign o_MemReq    = (r_state != IDLE);
   assign o_MemWe     = (r_state == D_BUSY) & i_DWeM;
   assign o_MemAddr   = (r_state == D_BUSY) ? i_DAddrM : i_IAddrF;
   assign o_MemWdata  = i_DWdataM;
   assign o_ReadDataM = r_ddone ? r_dbuf : i_MemRdata;
   assign o_InstrF    = r_idone ? r_ibuf : i_MemRdata;

   // Access sequencer: data first (older instruction), back-to-back hand-off on completion.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_dpend) begin
                  r_state <= D_BUSY;
               end else if (w_ipend) begin
                  r_state <= I_BUSY;
               end
            end
            D_BUSY: begin
               if (i_MemReady) begin
                  r_state <= w_ipend ? I_BUSY : IDLE;
               end
            end
            I_BUSY: begin
               if (i_MemReady) begin
                  r_state <= w_dpend ? D_BUSY : IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Done flags: consumption on pipeline advance wins over a same-cycle completion.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_ddone <= 1'b0;
         r_idone <= 1'b0;
      end else begin
         if (w_dclr) begin
            r_ddone <= 1'b0;
         end else if (w_dnow) begin
            r_ddone <= 1'b1;
         end
         if (w_iclr) begin
            r_idone <= 1'b0;
         end else if (w_inow & i_IReqF) begin
            r_idone <= 1'b1;
         end
      end
   end

   // Result buffers: loads only for data, and a flushed fetch is discarded.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_dbuf <= '0;
         r_ibuf <= '0;
      end else begin
         if (w_dnow & ~i_DWeM) begin
            r_dbuf <= i_MemRdata;
         end
         if (w_inow & i_IReqF) begin
            r_ibuf <= i_MemRdata;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int WDOG_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [WDOG_W:0] WDOG_LIMIT = (WDOG_W + 1)'(TIMEOUT_CYCLES);

   logic [WDOG_W-1:0] r_wdog;
   logic              r_timeout;
   logic [WDOG_W:0]   w_wdog_next;

   assign w_wdog_next = {1'b0, r_wdog} + 1'b1;
   assign o_Timeout   = r_timeout;

   // Watchdog: counts busy cycles without a response; the flag is sticky until reset.
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else if ((r_state == IDLE) || i_MemReady) begin
         r_wdog <= '0;
      end else begin
         if (r_wdog != '1) begin
            r_wdog <= w_wdog_next[WDOG_W-1:0];
         end
         if (w_wdog_next >= WDOG_LIMIT) begin
            r_timeout <= 1'b1;
         end
      end
   end
`else
   // Watchdog not built; the constant-false compare keeps the parameter referenced.
   assign o_Timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_IReqF = 1'b0;
   logic [31:0] i_IAddrF = '0;
   logic [31:0] o_InstrF;
   logic        i_DReqM = 1'b0;
   logic        i_DWeM = 1'b0;
   logic [31:0] i_DAddrM = '0;
   logic [31:0] i_DWdataM = '0;
   logic [31:0] o_ReadDataM;
   logic        i_StallExtF = 1'b0;
   logic        o_MemStall;
   logic        o_MemReq;
   logic        o_MemWe;
   logic [31:0] o_MemAddr;
   logic [31:0] o_MemWdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_rdy = 1'b0;
   logic        o_Timeout;

`ifdef ARB_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   mem_port_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .i_CLK(clk), .i_RST(rst_n),
      .i_IReqF(i_IReqF), .i_IAddrF(i_IAddrF), .o_InstrF(o_InstrF),
      .i_DReqM(i_DReqM), .i_DWeM(i_DWeM), .i_DAddrM(i_DAddrM), .i_DWdataM(i_DWdataM),
      .o_ReadDataM(o_ReadDataM), .i_StallExtF(i_StallExtF), .o_MemStall(o_MemStall),
      .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemWdata(o_MemWdata),
      .i_MemRdata(mem_rdata), .i_MemReady(mem_rdy), .o_Timeout(o_Timeout)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] mem  [logic [31:0]];
   logic [31:0] gold [logic [31:0]];
   int lat_cfg = 1;
   int cur_lat = 1;
   int busy_n = 0;
   int n_iacc = 0;
   int n_dacc = 0;

   function automatic logic [31:0] hashf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : hashf(a);
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : hashf(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Memory responder: variable latency counted in busy cycles, garbage data when not ready.
   always @(posedge clk) begin
      #2;
      if (!rst_n || !o_MemReq) begin
         busy_n = 0;
      end else if (busy_n == 0 || mem_rdy) begin
         busy_n = 1;
         cur_lat = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
      end else begin
         busy_n++;
      end
      mem_rdy   = rst_n && o_MemReq && (busy_n >= cur_lat);
      mem_rdata = (mem_rdy && !o_MemWe) ? mem_rd(o_MemAddr) : $urandom;
   end

   // Completed bus accesses: perform writes, count by address region.
   always @(negedge clk) begin
      if (rst_n && o_MemReq && mem_rdy) begin
         if (o_MemWe) mem[o_MemAddr] = o_MemWdata;
         if (o_MemAddr >= 32'h1000_0000) n_dacc++;
         else if (!o_MemWe) n_iacc++;
      end
   end

   typedef struct {
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] wdata;
      int          lat;
      int          exp_stall;
      logic [31:0] exp_instr;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic run_vec(input string name, input vec_t v);
      int sc;
      tick();
      i_IReqF = v.ireq; i_IAddrF = v.iaddr;
      i_DReqM = v.dreq; i_DWeM = v.dwe; i_DAddrM = v.daddr; i_DWdataM = v.wdata;
      lat_cfg = v.lat;
      sc = 0;
      sample();
      while (o_MemStall && sc < 50) begin
         sc++;
         tick();
         sample();
      end
      chk({name, "_stall_cycles"}, sc, v.exp_stall);
      if (v.ireq) chk({name, "_instr"}, o_InstrF, v.exp_instr);
      if (v.dreq && !v.dwe) chk({name, "_rdata"}, o_ReadDataM, v.exp_rdata);
      tick();
      i_IReqF = 1'b0; i_DReqM = 1'b0; i_DWeM = 1'b0;
   endtask

   vec_t vecs[8];
   vec_t v;
   int   base_i, base_d, exp_i, exp_d, stall_run;
   bit   have_i, have_d, cur_we, stalled;
   logic [31:0] cur_ia, cur_da, cur_wd;

   initial begin
      mem[32'h40]  = 32'h2008_0005;
      mem[32'h44]  = 32'h8C09_0100;
      mem[32'h48]  = 32'hAC0A_0104;
      mem[32'h80]  = 32'h0800_0010;
      mem[32'h100] = 32'hDEAD_BEEF;

      //           ireq iaddr       dreq dwe daddr       wdata         lat stall instr          rdata
      vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,          1, 1, 32'h2008_0005, 32'h0};
      vecs[1] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,          2, 4, 32'h8C09_0100, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'h1234_5678,  1, 1, 32'h0,         32'h0};
      vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h200, 32'h0,          3, 3, 32'h0,         32'h1234_5678};
      vecs[4] = '{1'b1, 32'h48, 1'b1, 1'b1, 32'h204, 32'h0BAD_F00D,  3, 6, 32'hAC0A_0104, 32'h0};
      vecs[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h204, 32'h0,          1, 1, 32'h0,         32'h0BAD_F00D};
      vecs[6] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0,          1, 2, 32'h0800_0010, 32'hDEAD_BEEF};
      vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,          1, 0, 32'h0,         32'h0};

      // Reset, then quiet idle.
      sample();
      chk("rst_memreq", o_MemReq, 0);
      chk("rst_memwe", o_MemWe, 0);
      chk("rst_timeout", o_Timeout, 0);
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         sample();
         chk("idle_memreq", o_MemReq, 0);
         chk("idle_stall", o_MemStall, 0);
         chk("idle_timeout", o_Timeout, 0);
         tick();
      end

      for (int k = 0; k < 8; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

      // Fetch + store: write strobe only in D_BUSY, DBuf keeps the previous load.
      tick();
      i_IReqF = 1'b1; i_IAddrF = 32'h44;
      i_DReqM = 1'b1; i_DWeM = 1'b1; i_DAddrM = 32'h208; i_DWdataM = 32'hCAFE_F00D;
      lat_cfg = 2;
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("st_memwe", o_MemWe, (k == 1 || k == 2));
         chk("st_stall", o_MemStall, (k < 4));
         if (k == 1 || k == 2) begin
            chk("st_wdata", o_MemWdata, 32'hCAFE_F00D);
            chk("st_addr", o_MemAddr, 32'h208);
         end
         if (k >= 3) chk("st_dbuf_kept", o_ReadDataM, 32'hDEAD_BEEF);
         if (k < 4) tick();
      end
      chk("st_instr", o_InstrF, 32'h8C09_0100);
      tick();
      i_IReqF = 1'b0; i_DReqM = 1'b0; i_DWeM = 1'b0;
      v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h0, 1, 1, 32'h0, 32'hCAFE_F00D};
      run_vec("st_readback", v);

      // Fetch completes under external F/D stall: buffered, no second access.
      base_i = n_iacc;
      tick();
      i_IReqF = 1'b1; i_IAddrF = 32'h40; i_StallExtF = 1'b1; lat_cfg = 1;
      sample();
      chk("ext_stall_c0", o_MemStall, 1);
      tick();
      sample();
      chk("ext_done_stall", o_MemStall, 0);
      chk("ext_done_instr", o_InstrF, 32'h2008_0005);
      for (int k = 0; k < 3; k++) begin
         tick();
         sample();
         chk("ext_hold_instr", o_InstrF, 32'h2008_0005);
         chk("ext_hold_memreq", o_MemReq, 0);
         chk("ext_hold_stall", o_MemStall, 0);
      end
      tick();
      i_StallExtF = 1'b0;
      sample();
      chk("ext_release_instr", o_InstrF, 32'h2008_0005);
      tick();
      i_IReqF = 1'b0;
      tick();
      chk("ext_single_access", n_iacc - base_i, 1);

      // Flush mid I_BUSY, then a new fetch at 0x80.
      base_i = n_iacc;
      tick();
      i_IReqF = 1'b1; i_IAddrF = 32'h60; lat_cfg = 3;
      sample();
      chk("fl_c0_stall", o_MemStall, 1);
      tick();
      i_IReqF = 1'b0;
      sample();
      chk("fl_c1_memreq", o_MemReq, 1);
      chk("fl_c1_stall", o_MemStall, 0);
      tick();
      tick();
      sample();
      chk("fl_c3_ready", mem_rdy & o_MemReq, 1);
      v = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1, 32'h0800_0010, 32'h0};
      run_vec("fl_new_fetch", v);
      tick();
      chk("fl_access_count", n_iacc - base_i, 2);

      // Watchdog: 8 busy cycles without ready, sticky until reset.
      tick();
      i_IReqF = 1'b1; i_IAddrF = 32'h1000; lat_cfg = 20;
      for (int k = 0; k < 10; k++) begin
         sample();
         if (k == 8) chk("to_not_yet", o_Timeout, 0);
         if (k == 9) chk("to_set", o_Timeout, TO_EN);
         if (k < 9) tick();
      end
      tick(); tick();
      sample();
      chk("to_sticky", o_Timeout, TO_EN);
      tick();
      rst_n = 1'b0; i_IReqF = 1'b0;
      sample();
      chk("to_rst_clear", o_Timeout, 0);
      chk("to_rst_memreq", o_MemReq, 0);
      tick();
      rst_n = 1'b1;
      sample();
      chk("to_post_stall", o_MemStall, 0);
      chk("to_post_memreq", o_MemReq, 0);

      // Randomized pipeline against a transaction-level model.
      lat_cfg = 0;
      base_i = n_iacc; base_d = n_dacc;
      exp_i = 0; exp_d = 0; stall_run = 0; have_i = 0; have_d = 0;
      tick();
      for (int cyc = 0; cyc < 700; cyc++) begin
         sample();
         if (!i_IReqF && !i_DReqM) chk("rnd_idle_stall", o_MemStall, 0);
         if (o_MemStall) begin
            stall_run++;
            if (stall_run > 12) begin
               chk("rnd_stall_bound", stall_run, 12);
               break;
            end
         end else begin
            stall_run = 0;
            if (have_d) begin
               if (!cur_we) chk("rnd_load", o_ReadDataM, gold_rd(cur_da));
               else gold[cur_da] = cur_wd;
               exp_d++;
               have_d = 0;
            end
            if (have_i && !i_StallExtF) begin
               chk("rnd_instr", o_InstrF, hashf(cur_ia));
               exp_i++;
               have_i = 0;
            end
         end
         stalled = o_MemStall;
         tick();
         if (!stalled) begin
            if (cyc < 640) begin
               if (!have_d && $urandom_range(0, 1) == 1) begin
                  have_d = 1;
                  cur_we = $urandom_range(0, 1);
                  cur_da = 32'h1000_0000 + 4 * $urandom_range(0, 7);
                  cur_wd = $urandom;
               end
               if (!have_i && $urandom_range(0, 3) != 0) begin
                  have_i = 1;
                  cur_ia = 32'h1000 + 4 * $urandom_range(0, 255);
               end
               i_StallExtF = ($urandom_range(0, 3) == 0);
            end else begin
               i_StallExtF = 1'b0;
            end
         end
         i_IReqF = have_i; i_IAddrF = cur_ia;
         i_DReqM = have_d; i_DWeM = cur_we; i_DAddrM = cur_da; i_DWdataM = cur_wd;
      end
      tick();
      chk("rnd_drained", {30'd0, have_i, have_d}, 0);
      chk("rnd_fetch_accesses", n_iacc - base_i, exp_i);
      chk("rnd_data_accesses", n_dacc - base_d, exp_d);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
